ahb_arbiter_2m: RTL and testbench

- Two-master AHB arbiter and address/data multiplexer between the CPU-side AHB master bridges and the shared slave bus.
- Master 0 is the instruction-fetch bridge; master 1 is the data-memory bridge.
- Consumes each bridge's HBUSREQ and transfer controls, and returns HGRANT, HRDATA and HREADY.
- Forwards the owner's address phase and the data-phase owner's write data to the slave side.

---
 rtl/ahb_arbiter_2m_pkg.sv | 29 ++
 rtl/ahb_arbiter_2m_if.sv | 46 ++++
 rtl/ahb_arbiter_2m_pick.sv | 31 +++
 rtl/ahb_arbiter_2m.sv | 89 ++++++++
 tb/tb_ahb_arbiter_2m.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arbiter_2m_pkg.sv
// Shared AHB codes and sizing helpers for the two-master arbiter.
package ahb_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    // Hold counter must represent 0..max_hold and never collapse to zero width.
    function automatic int hold_w(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/ahb_arbiter_2m_if.sv
// Bus bundle between the two master bridges, the arbiter and the shared slave side.
interface ahb_arbiter_2m_if;
    logic        m0_hbusreq;
    logic [31:0] m0_haddr;
    logic [1:0]  m0_htrans;
    logic [2:0]  m0_hsize;
    logic [2:0]  m0_hburst;
    logic        m0_hwrite;
    logic [31:0] m0_hwdata;
    logic        m1_hbusreq;
    logic [31:0] m1_haddr;
    logic [1:0]  m1_htrans;
    logic [2:0]  m1_hsize;
    logic [2:0]  m1_hburst;
    logic        m1_hwrite;
    logic [31:0] m1_hwdata;
    logic        m0_hgrant;
    logic        m1_hgrant;
    logic [31:0] hrdata;
    logic        hready;
    logic        hmaster;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hwrite;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;

    modport slave (
        input  m0_hbusreq, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hwrite, m0_hwdata,
        input  m1_hbusreq, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hwrite, m1_hwdata,
        input  s_hrdata, s_hready,
        output m0_hgrant, m1_hgrant, hrdata, hready, hmaster,
        output s_haddr, s_htrans, s_hsize, s_hburst, s_hwrite, s_hwdata
    );

    modport master (
        output m0_hbusreq, m0_haddr, m0_htrans, m0_hsize, m0_hburst, m0_hwrite, m0_hwdata,
        output m1_hbusreq, m1_haddr, m1_htrans, m1_hsize, m1_hburst, m1_hwrite, m1_hwdata,
        output s_hrdata, s_hready,
        input  m0_hgrant, m1_hgrant, hrdata, hready, hmaster,
        input  s_haddr, s_htrans, s_hsize, s_hburst, s_hwrite, s_hwdata
    );
endinterface

// File: rtl/ahb_arbiter_2m_pick.sv
// Next-owner selection: keep, preempt, prioritise or park. Purely combinational.
module ahb_arb_pick (
    input  logic [1:0] req_i,
    input  logic       owner_i,
    input  logic       parked_i,
    input  logic       hold_exp_i,
    input  logic       last_i,
    input  logic       rr_i,
    input  logic       dflt_i,
    output logic       next_o
);
    logic       other;
    logic [1:0] cand;

    always_comb begin
        other = ~owner_i;
        cand  = req_i;
        // An expired owner is dropped from the candidates so the handover is real.
        if (hold_exp_i && req_i[other]) cand[owner_i] = 1'b0;
        next_o = dflt_i;
        // A parked owner has no claim; only a requesting owner may keep the bus.
        if (!parked_i && cand[owner_i])
            next_o = owner_i;
        else if (cand == 2'b11)
            next_o = rr_i ? ~last_i : 1'b1;
        else if (cand[1])
            next_o = 1'b1;
        else if (cand[0])
            next_o = 1'b0;
    end
endmodule

// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB arbiter: ownership registers, hold limiter and address/write-data muxes.
module ahb_arbiter_2m
    import ahb_arbiter_2m_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0,
    parameter int PRIO_MODE      = 0,
    parameter int MAX_HOLD       = 8
) (
    input logic              clk,
    input logic              rst,
    ahb_arbiter_2m_if.slave  bus
);
    localparam int   HW   = hold_w(MAX_HOLD);
    localparam logic DFLT = 1'(DEFAULT_MASTER);

    logic          hmaster_q,   hmaster_d;
    logic          hmaster_dph_q, hmaster_dph_d;
    logic          last_q,      last_d;
    logic          parked_q,    parked_d;
    logic [HW-1:0] hold_cnt_q,  hold_cnt_d;
    logic [1:0]    req;
    logic          hold_exp;
    logic          owner_nxt;

    assign req      = {bus.m1_hbusreq, bus.m0_hbusreq};
    assign hold_exp = (MAX_HOLD != 0) && (hold_cnt_q >= HW'(MAX_HOLD));

    ahb_arb_pick u_pick (
        .req_i      (req),
        .owner_i    (hmaster_q),
        .parked_i   (parked_q),
        .hold_exp_i (hold_exp),
        .last_i     (last_q),
        .rr_i       (PRIO_MODE != 0),
        .dflt_i     (DFLT),
        .next_o     (owner_nxt)
    );

    always_comb begin
        hmaster_d     = hmaster_q;
        hmaster_dph_d = hmaster_dph_q;
        last_d        = last_q;
        parked_d      = parked_q;
        hold_cnt_d    = hold_cnt_q;
        if (bus.s_hready) begin
            hmaster_d     = owner_nxt;
            hmaster_dph_d = hmaster_q;
            parked_d      = ~|req;
            if (owner_nxt != hmaster_q) begin
                hold_cnt_d = '0;
                last_d     = owner_nxt;
            end else if (req[~hmaster_q] && hold_cnt_q != HW'(MAX_HOLD)) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hmaster_q     <= DFLT;
            hmaster_dph_q <= DFLT;
            last_q        <= DFLT;
            parked_q      <= 1'b1;
            hold_cnt_q    <= '0;
        end else begin
            hmaster_q     <= hmaster_d;
            hmaster_dph_q <= hmaster_dph_d;
            last_q        <= last_d;
            parked_q      <= parked_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // Grant and address-phase owner move together, so one-hot is by construction.
    assign bus.m0_hgrant = ~hmaster_q;
    assign bus.m1_hgrant = hmaster_q;
    assign bus.hmaster   = hmaster_q;

    assign bus.s_haddr  = hmaster_q ? bus.m1_haddr  : bus.m0_haddr;
    assign bus.s_hsize  = hmaster_q ? bus.m1_hsize  : bus.m0_hsize;
    assign bus.s_hburst = hmaster_q ? bus.m1_hburst : bus.m0_hburst;
    assign bus.s_hwrite = hmaster_q ? bus.m1_hwrite : bus.m0_hwrite;
    assign bus.s_htrans = !req[hmaster_q] ? HTRANS_IDLE :
                          (hmaster_q ? bus.m1_htrans : bus.m0_htrans);
    assign bus.s_hwdata = hmaster_dph_q ? bus.m1_hwdata : bus.m0_hwdata;

    assign bus.hrdata = bus.s_hrdata;
    assign bus.hready = bus.s_hready;
endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Bench for ahb_arbiter_2m: two configurations driven in lockstep against a bus-level model.
module tb_ahb_arbiter_2m;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ahb_arbiter_2m_if ia ();
    ahb_arbiter_2m_if ib ();

    // Config A: park 0, fixed priority, hold limit 4. Config B: park 1, round-robin, no limit.
    ahb_arbiter_2m #(.DEFAULT_MASTER(0), .PRIO_MODE(0), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    ahb_arbiter_2m #(.DEFAULT_MASTER(1), .PRIO_MODE(1), .MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    assign ib.m0_hbusreq = ia.m0_hbusreq;
    assign ib.m0_haddr   = ia.m0_haddr;
    assign ib.m0_htrans  = ia.m0_htrans;
    assign ib.m0_hsize   = ia.m0_hsize;
    assign ib.m0_hburst  = ia.m0_hburst;
    assign ib.m0_hwrite  = ia.m0_hwrite;
    assign ib.m0_hwdata  = ia.m0_hwdata;
    assign ib.m1_hbusreq = ia.m1_hbusreq;
    assign ib.m1_haddr   = ia.m1_haddr;
    assign ib.m1_htrans  = ia.m1_htrans;
    assign ib.m1_hsize   = ia.m1_hsize;
    assign ib.m1_hburst  = ia.m1_hburst;
    assign ib.m1_hwrite  = ia.m1_hwrite;
    assign ib.m1_hwdata  = ia.m1_hwdata;
    assign ib.s_hrdata   = ia.s_hrdata;
    assign ib.s_hready   = ia.s_hready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the address phase, who owns the data phase.
    int   P_PRIO[2] = '{0, 1};
    int   P_MAXH[2] = '{4, 0};
    int   P_DFLT[2] = '{0, 1};
    int   own[2], ownd[2], hold[2], last[2];
    bit   parked[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = P_DFLT[k]; ownd[k] = P_DFLT[k]; hold[k] = 0;
            last[k] = P_DFLT[k]; parked[k] = 1;
        end
    endfunction

    task automatic tick();
        int  n_own[2], n_ownd[2], n_hold[2], n_last[2];
        bit  n_parked[2];
        bit  r[2];
        r[0] = ia.m0_hbusreq; r[1] = ia.m1_hbusreq;
        for (int k = 0; k < 2; k++) begin
            int  cur, oth, nxt;
            bit  expired, c0, c1;
            n_own[k] = own[k]; n_ownd[k] = ownd[k]; n_hold[k] = hold[k];
            n_last[k] = last[k]; n_parked[k] = parked[k];
            if (ia.s_hready) begin
                cur = own[k]; oth = 1 - cur;
                expired = (P_MAXH[k] != 0) && (hold[k] >= P_MAXH[k]) && r[oth];
                c0 = r[0] && !(expired && cur == 0);
                c1 = r[1] && !(expired && cur == 1);
                if (!parked[k] && r[cur] && !expired) nxt = cur;
                else if (c0 && c1) nxt = (P_PRIO[k] != 0) ? 1 - last[k] : 1;
                else if (c1) nxt = 1;
                else if (c0) nxt = 0;
                else nxt = P_DFLT[k];
                if (nxt != cur) begin n_hold[k] = 0; n_last[k] = nxt; end
                else if (r[oth] && hold[k] < P_MAXH[k]) n_hold[k] = hold[k] + 1;
                n_ownd[k] = cur; n_own[k] = nxt; n_parked[k] = !r[0] && !r[1];
            end
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) begin
            own[k] = n_own[k]; ownd[k] = n_ownd[k]; hold[k] = n_hold[k];
            last[k] = n_last[k]; parked[k] = n_parked[k];
        end
    endtask

    function automatic logic [108:0] obs(input int k);
        if (k == 0)
            return {ia.m0_hgrant, ia.m1_hgrant, ia.hmaster, ia.s_haddr, ia.s_htrans, ia.s_hsize,
                    ia.s_hburst, ia.s_hwrite, ia.s_hwdata, ia.hrdata, ia.hready};
        return {ib.m0_hgrant, ib.m1_hgrant, ib.hmaster, ib.s_haddr, ib.s_htrans, ib.s_hsize,
                ib.s_hburst, ib.s_hwrite, ib.s_hwdata, ib.hrdata, ib.hready};
    endfunction

    function automatic logic [108:0] expv(input int k);
        bit o, od, rq;
        o  = (own[k] == 1);
        od = (ownd[k] == 1);
        rq = o ? ia.m1_hbusreq : ia.m0_hbusreq;
        return {!o, o, o,
                o ? ia.m1_haddr : ia.m0_haddr,
                rq ? (o ? ia.m1_htrans : ia.m0_htrans) : 2'b00,
                o ? ia.m1_hsize : ia.m0_hsize,
                o ? ia.m1_hburst : ia.m0_hburst,
                o ? ia.m1_hwrite : ia.m0_hwrite,
                od ? ia.m1_hwdata : ia.m0_hwdata,
                ia.s_hrdata, ia.s_hready};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ia.m0_hbusreq = 0; ia.m1_hbusreq = 0;
        ia.m0_haddr = 32'h0000_1000; ia.m1_haddr = 32'h8000_0000;
        ia.m0_htrans = 2'b10; ia.m1_htrans = 2'b10;
        ia.m0_hsize = 3'b010; ia.m1_hsize = 3'b010;
        ia.m0_hburst = 3'b000; ia.m1_hburst = 3'b000;
        ia.m0_hwrite = 0; ia.m1_hwrite = 0;
        ia.m0_hwdata = 32'h1111_1111; ia.m1_hwdata = 32'h2222_2222;
        ia.s_hrdata = 32'h5A5A_0001; ia.s_hready = 1;
        model_reset();
        tick(); tick();
        checks++;
        if ({ia.m0_hgrant, ia.m1_hgrant, ia.hmaster, ia.s_htrans} !== {1'b1, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_a got g0=%b g1=%b hm=%b htrans=%b want 1 0 0 00",
                     ia.m0_hgrant, ia.m1_hgrant, ia.hmaster, ia.s_htrans);
        end
        checks++;
        if ({ib.m0_hgrant, ib.m1_hgrant, ib.hmaster} !== 3'b011) begin
            errors++;
            $display("FAIL reset_b got g0=%b g1=%b hm=%b want 0 1 1", ib.m0_hgrant, ib.m1_hgrant, ib.hmaster);
        end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++; $display("FAIL reset_vec%0d got %h want %h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_handover();
        tick();
        ia.m1_hbusreq = 1; ia.m1_haddr = 32'h8000_0010; ia.m1_hwdata = 32'hDEAD_BEEF;
        ia.m1_hwrite = 1; ia.m1_htrans = 2'b10;
        #1;
        checks++;
        if (ia.m0_hgrant !== 1'b1) begin errors++; $display("FAIL handover_pre got g0=%b want 1", ia.m0_hgrant); end
        tick();
        checks++;
        if ({ia.m1_hgrant, ia.s_haddr, ia.s_htrans} !== {1'b1, 32'h8000_0010, 2'b10}) begin
            errors++;
            $display("FAIL handover_addr got g1=%b addr=%h tr=%b want 1 80000010 10", ia.m1_hgrant, ia.s_haddr, ia.s_htrans);
        end
        tick();
        checks++;
        if (ia.s_hwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL handover_wdata got %h want deadbeef", ia.s_hwdata); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++; $display("FAIL handover_vec%0d got %h want %h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_simultaneous();
        ia.m0_hbusreq = 0; ia.m1_hbusreq = 0;
        tick(); tick();
        ia.m0_hbusreq = 1; ia.m1_hbusreq = 1;
        tick();
        checks++;
        if (ia.m1_hgrant !== 1'b1) begin errors++; $display("FAIL simul_fixed got g1=%b want 1", ia.m1_hgrant); end
        checks++;
        if (ib.m0_hgrant !== 1'b1) begin errors++; $display("FAIL simul_rr got g0=%b want 1", ib.m0_hgrant); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++; $display("FAIL simul_vec%0d got %h want %h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_ready_stall();
        ia.m1_hbusreq = 0; ia.m0_hbusreq = 1; ia.s_hready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ia.m1_hgrant !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got g1=%b want 1", i, ia.m1_hgrant); end
        end
        ia.s_hready = 1;
        tick();
        checks++;
        if (ia.m0_hgrant !== 1'b1) begin errors++; $display("FAIL stall_release got g0=%b want 1", ia.m0_hgrant); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++; $display("FAIL stall_vec%0d got %h want %h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_max_hold();
        tick();
        ia.m1_hbusreq = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ia.m0_hgrant !== 1'b1) begin errors++; $display("FAIL hold_keep%0d got g0=%b want 1", i, ia.m0_hgrant); end
        end
        tick();
        checks++;
        if (ia.m1_hgrant !== 1'b1) begin errors++; $display("FAIL hold_preempt got g1=%b want 1", ia.m1_hgrant); end
        // A fresh count for the new owner gives it the full four edges.
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ia.m1_hgrant !== 1'b1) begin errors++; $display("FAIL hold_fresh%0d got g1=%b want 1", i, ia.m1_hgrant); end
        end
        tick();
        checks++;
        if (ia.m0_hgrant !== 1'b1) begin errors++; $display("FAIL hold_back got g0=%b want 1", ia.m0_hgrant); end
        checks++;
        if (ib.m0_hgrant !== 1'b1) begin errors++; $display("FAIL hold_nolimit got g0=%b want 1", ib.m0_hgrant); end
    endtask

    task automatic test_async_reset();
        ia.m0_hbusreq = 0; ia.m1_hbusreq = 1; ia.m1_hwrite = 1; ia.m1_hwdata = 32'hCAFE_F00D;
        tick(); tick();
        checks++;
        if ({ia.hmaster, ia.s_hwdata} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL arst_pre got hm=%b wd=%h want 1 cafef00d", ia.hmaster, ia.s_hwdata);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({ia.m0_hgrant, ia.hmaster, ia.s_hwdata} !== {1'b1, 1'b0, ia.m0_hwdata}) begin
            errors++; $display("FAIL arst_a got g0=%b hm=%b wd=%h want 1 0 %h", ia.m0_hgrant, ia.hmaster, ia.s_hwdata, ia.m0_hwdata);
        end
        checks++;
        if ({ib.m1_hgrant, ib.hmaster} !== 2'b11) begin
            errors++; $display("FAIL arst_b got g1=%b hm=%b want 1 1", ib.m1_hgrant, ib.hmaster);
        end
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin errors++; $display("FAIL arst_vec%0d got %h want %h", k, obs(k), expv(k)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ia.m0_hbusreq = 1'($urandom_range(0, 1));
            ia.m1_hbusreq = 1'($urandom_range(0, 1));
            ia.s_hready   = ($urandom_range(0, 3) != 0);
            ia.m0_haddr = $urandom(); ia.m1_haddr = $urandom();
            ia.m0_htrans = 2'($urandom()); ia.m1_htrans = 2'($urandom());
            ia.m0_hsize = 3'($urandom()); ia.m1_hsize = 3'($urandom());
            ia.m0_hburst = 3'($urandom()); ia.m1_hburst = 3'($urandom());
            ia.m0_hwrite = 1'($urandom()); ia.m1_hwrite = 1'($urandom());
            ia.m0_hwdata = $urandom(); ia.m1_hwdata = $urandom();
            ia.s_hrdata = $urandom();
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin errors++; $display("FAIL rand%0d_vec%0d got %h want %h", i, k, obs(k), expv(k)); end
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handover();
        test_simultaneous();
        test_ready_stall();
        test_max_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
